// File: rtl/otp_stream_ctrl.sv
// Sequencer for the 16-bit one-time-pad cryptor. It pairs each message word with one fresh key word,
// presents the pair for one cycle, captures the result and streams it out with valid/ready.
module otp_stream_ctrl #(
   parameter int unsigned WORD_W    = 16,
   parameter int unsigned MAX_WORDS = 15,
   parameter int unsigned CNT_W     = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  len,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              err_len,
   input  logic              in_valid,
   input  logic [WORD_W-1:0] in_word,
   output logic              in_ready,
   input  logic              key_valid,
   input  logic [WORD_W-1:0] key_word,
   output logic              key_ready,
   output logic [WORD_W-1:0] crypt_msg,
   output logic [WORD_W-1:0] crypt_key,
   input  logic [WORD_W-1:0] crypt_out,
   output logic              out_valid,
   output logic [WORD_W-1:0] out_word,
   output logic              out_last,
   input  logic              out_ready
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_XOR, S_CAPT, S_EMIT, S_DONE} state_t;

   state_t            r_state, w_next;
   logic [CNT_W-1:0]  r_len, r_cnt;
   logic [WORD_W-1:0] r_msg, r_key, r_out;
   logic              r_err_len;
   logic              w_len_ok, w_hs, w_last, w_abort;

   assign w_len_ok = (len != '0) && (32'(len) <= MAX_WORDS);
   assign w_hs     = (r_state == S_LOAD) && in_valid && key_valid;
   assign w_last   = (r_cnt == r_len - CNT_W'(1));
   assign w_abort  = abort && (r_state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start && w_len_ok) w_next = S_LOAD;
         S_LOAD:  if (w_hs) w_next = S_XOR;
         S_XOR:   w_next = S_CAPT;
         S_CAPT:  w_next = S_EMIT;
         S_EMIT:  if (out_ready) w_next = w_last ? S_DONE : S_LOAD;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (w_abort) w_next = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len     <= '0;
         r_cnt     <= '0;
         r_msg     <= '0;
         r_key     <= '0;
         r_out     <= '0;
         r_err_len <= 1'b0;
      end else begin
         r_err_len <= (r_state == S_IDLE) && start && !w_len_ok;
         // An aborted pair is still consumed by the handshake but never latched.
         if (w_abort) begin
            r_msg <= '0;
            r_key <= '0;
            r_out <= '0;
         end else begin
            case (r_state)
               S_IDLE: if (start && w_len_ok) begin
                  r_len <= len;
                  r_cnt <= '0;
               end
               S_LOAD: if (w_hs) begin
                  r_msg <= in_word;
                  r_key <= key_word;
               end
               S_CAPT: begin
                  r_out <= crypt_out;
                  r_msg <= '0;
                  r_key <= '0;
               end
               S_EMIT: if (out_ready && !w_last) r_cnt <= r_cnt + CNT_W'(1);
               default: ;
            endcase
         end
      end
   end

   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);
   assign err_len   = r_err_len;
   assign in_ready  = w_hs;
   assign key_ready = w_hs;
   assign crypt_msg = (r_state == S_XOR) ? r_msg : '0;
   assign crypt_key = (r_state == S_XOR) ? r_key : '0;
   assign out_valid = (r_state == S_EMIT);
   assign out_last  = (r_state == S_EMIT) && w_last;
   assign out_word  = r_out;

endmodule

// File: tb/tb_otp_stream_ctrl.sv
// Randomized bench for otp_stream_ctrl: results are predicted as msg ^ key per consumed pair,
// with a registered cryptor model closing the loop.
module tb_otp_stream_ctrl;
   localparam int W = 16;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          start = 1'b0, abort = 1'b0, in_valid = 1'b0, key_valid = 1'b0, out_ready = 1'b0;
   logic [3:0]    len = '0;
   logic [W-1:0]  in_word = '0, key_word = '0, crypt_out = '0;
   logic          busy, done, err_len, in_ready, key_ready, out_valid, out_last;
   logic [W-1:0]  crypt_msg, crypt_key, out_word;

   logic          b_start = 1'b0, b_abort = 1'b0;
   logic [3:0]    b_len = '0;
   logic          b_busy, b_done, b_err_len, b_in_ready, b_key_ready, b_out_valid, b_out_last;
   logic [W-1:0]  b_crypt_msg, b_crypt_key, b_out_word;

   int            checks = 0, passed = 0;
   logic [W-1:0]  m_w [16];
   logic [W-1:0]  k_w [16];

   otp_stream_ctrl #(.WORD_W(16), .MAX_WORDS(15), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
      .busy(busy), .done(done), .err_len(err_len),
      .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready),
      .key_valid(key_valid), .key_word(key_word), .key_ready(key_ready),
      .crypt_msg(crypt_msg), .crypt_key(crypt_key), .crypt_out(crypt_out),
      .out_valid(out_valid), .out_word(out_word), .out_last(out_last), .out_ready(out_ready));

   otp_stream_ctrl #(.WORD_W(16), .MAX_WORDS(8), .CNT_W(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(b_start), .len(b_len), .abort(b_abort),
      .busy(b_busy), .done(b_done), .err_len(b_err_len),
      .in_valid(1'b0), .in_word(16'h0000), .in_ready(b_in_ready),
      .key_valid(1'b0), .key_word(16'h0000), .key_ready(b_key_ready),
      .crypt_msg(b_crypt_msg), .crypt_key(b_crypt_key), .crypt_out(16'h0000),
      .out_valid(b_out_valid), .out_word(b_out_word), .out_last(b_out_last), .out_ready(1'b0));

   always #5 clk = ~clk;

   // Cryptor model: registered XOR, result valid one clock after presentation.
   always @(posedge clk) crypt_out <= crypt_msg ^ crypt_key;

   task automatic run_msg(input int n, input int vld_pct, input int rdy_pct);
      int sent, got, cyc, hs_cyc;
      logic [W-1:0] held;
      bit held_v, fin;
      sent = 0; got = 0; cyc = 0; hs_cyc = -10; held_v = 0; fin = 0; held = '0;
      @(negedge clk); start = 1'b1; len = 4'(n);
      @(negedge clk); start = 1'b0;
      checks++; if (busy !== 1'b1) $display("FAIL start_busy: got %b want 1", busy); else passed++;
      while (!fin && cyc < 3000) begin
         start     = ($urandom_range(3) == 0);
         len       = 4'($urandom_range(15));
         in_valid  = (sent < n) && ($urandom_range(99) < vld_pct);
         key_valid = ($urandom_range(99) < vld_pct);
         in_word   = m_w[sent];
         key_word  = k_w[sent];
         out_ready = ($urandom_range(99) < rdy_pct);
         #1;
         checks++;
         if (in_ready !== key_ready) $display("FAIL ready_pair: in_ready %b key_ready %b", in_ready, key_ready);
         else passed++;
         if (in_ready === 1'b1) begin
            checks++;
            if (!(in_valid && key_valid)) $display("FAIL ready_w/o_valid: in_valid %b key_valid %b", in_valid, key_valid);
            else passed++;
            hs_cyc = cyc;
            sent++;
         end
         checks++;
         if (cyc == hs_cyc + 1) begin
            if (crypt_msg !== m_w[sent-1] || crypt_key !== k_w[sent-1])
               $display("FAIL crypt_present: got %h/%h want %h/%h", crypt_msg, crypt_key, m_w[sent-1], k_w[sent-1]);
            else passed++;
         end else begin
            if (crypt_msg !== '0 || crypt_key !== '0)
               $display("FAIL crypt_idle: got %h/%h want 0000/0000", crypt_msg, crypt_key);
            else passed++;
         end
         if (out_valid === 1'b1) begin
            checks++;
            if (!held_v) begin
               if (cyc - hs_cyc != 3) $display("FAIL latency: got %0d want 3", cyc - hs_cyc);
               else passed++;
            end else begin
               if (out_word !== held) $display("FAIL hold_stable: got %h want %h", out_word, held);
               else passed++;
            end
            checks++;
            if (out_word !== (m_w[got] ^ k_w[got]))
               $display("FAIL out_word[%0d]: got %h want %h", got, out_word, m_w[got] ^ k_w[got]);
            else passed++;
            checks++;
            if (out_last !== (got == n - 1)) $display("FAIL out_last[%0d]: got %b want %b", got, out_last, got == n - 1);
            else passed++;
            if (out_ready) begin got++; held_v = 0; end
            else begin held_v = 1; held = out_word; end
         end
         checks++; if (err_len !== 1'b0) $display("FAIL err_len_busy: got %b want 0", err_len); else passed++;
         if (done === 1'b1) begin
            checks++; if (got != n) $display("FAIL words_out: got %0d want %0d", got, n); else passed++;
            checks++; if (sent != n) $display("FAIL pairs_used: got %0d want %0d", sent, n); else passed++;
            fin = 1;
         end
         @(negedge clk); cyc++;
      end
      start = 1'b0; in_valid = 1'b0; key_valid = 1'b0; out_ready = 1'b0;
      checks++; if (!fin) $display("FAIL msg_timeout: got no done want done"); else passed++;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) $display("FAIL after_done: busy %b done %b want 0 0", busy, done);
      else passed++;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, err_len, in_ready, key_ready, out_valid, out_last} !== 7'b0 ||
          out_word !== '0 || crypt_msg !== '0 || crypt_key !== '0)
         $display("FAIL reset_outputs: got %b %h %h %h want all zero",
                  {busy, done, err_len, in_ready, key_ready, out_valid, out_last}, out_word, crypt_msg, crypt_key);
      else passed++;
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_single;
      m_w[0] = 16'h0000; k_w[0] = 16'hFFFF;
      run_msg(1, 100, 100);
   endtask

   task automatic test_multi;
      m_w[0] = 16'hAAAA; k_w[0] = 16'h5555;
      m_w[1] = 16'h5555; k_w[1] = 16'h5555;
      m_w[2] = 16'hFFFF; k_w[2] = 16'h5555;
      run_msg(3, 100, 100);
   endtask

   task automatic test_backpressure;
      m_w[0] = 16'h0000; k_w[0] = 16'hFFFF;
      m_w[1] = 16'h1234; k_w[1] = 16'h00FF;
      run_msg(2, 100, 15);
   endtask

   task automatic test_key_wait;
      for (int i = 0; i < 16; i++) begin m_w[i] = 16'($urandom); k_w[i] = 16'($urandom); end
      run_msg(5, 40, 100);
   endtask

   task automatic test_random;
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 16; i++) begin m_w[i] = 16'($urandom); k_w[i] = 16'($urandom); end
         run_msg(int'($urandom_range(15, 1)), int'($urandom_range(100, 30)), int'($urandom_range(100, 30)));
      end
   endtask

   task automatic test_err_len;
      @(negedge clk); start = 1'b1; len = 4'd0;
      @(negedge clk); start = 1'b0;
      checks++;
      if (err_len !== 1'b1 || busy !== 1'b0) $display("FAIL len0: err %b busy %b want 1 0", err_len, busy);
      else passed++;
      @(negedge clk);
      checks++; if (err_len !== 1'b0) $display("FAIL err_pulse_width: got %b want 0", err_len); else passed++;
      start = 1'b1; len = 4'd15;
      @(negedge clk); start = 1'b0;
      checks++;
      if (err_len !== 1'b0 || busy !== 1'b1) $display("FAIL len15: err %b busy %b want 0 1", err_len, busy);
      else passed++;
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      checks++; if (busy !== 1'b0) $display("FAIL abort_load: busy %b want 0", busy); else passed++;
      b_start = 1'b1; b_len = 4'd9;
      @(negedge clk); b_start = 1'b0;
      checks++;
      if (b_err_len !== 1'b1 || b_busy !== 1'b0) $display("FAIL max8_len9: err %b busy %b want 1 0", b_err_len, b_busy);
      else passed++;
      b_start = 1'b1; b_len = 4'd8;
      @(negedge clk); b_start = 1'b0;
      checks++;
      if (b_err_len !== 1'b0 || b_busy !== 1'b1) $display("FAIL max8_len8: err %b busy %b want 0 1", b_err_len, b_busy);
      else passed++;
      b_abort = 1'b1;
      @(negedge clk); b_abort = 1'b0;
      checks++; if (b_busy !== 1'b0) $display("FAIL max8_abort: busy %b want 0", b_busy); else passed++;
   endtask

   task automatic test_abort;
      int seen, cyc;
      @(negedge clk); start = 1'b1; len = 4'd4;
      @(negedge clk); start = 1'b0;
      in_valid = 1'b1; key_valid = 1'b1; out_ready = 1'b1;
      in_word = 16'hC3C3; key_word = 16'h3C3C;
      seen = 0; cyc = 0;
      while (cyc < 200) begin
         if (out_valid === 1'b1) begin seen++; if (seen == 2) break; end
         @(negedge clk); cyc++;
      end
      checks++; if (seen != 2) $display("FAIL abort_reach_word2: got %0d want 2", seen); else passed++;
      abort = 1'b1;
      @(negedge clk); abort = 1'b0; in_valid = 1'b0; key_valid = 1'b0;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || out_word !== '0 || crypt_key !== '0 || done !== 1'b0)
         $display("FAIL abort_state: busy %b ov %b ow %h ck %h done %b want 0 0 0000 0000 0",
                  busy, out_valid, out_word, crypt_key, done);
      else passed++;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) $display("FAIL abort_quiet: done %b busy %b want 0 0", done, busy);
         else passed++;
      end
      m_w[0] = 16'h0F0F; k_w[0] = 16'h00FF;
      run_msg(1, 100, 100);
   endtask

   task automatic test_reset_mid;
      @(negedge clk); start = 1'b1; len = 4'd1;
      @(negedge clk); start = 1'b0;
      in_valid = 1'b1; key_valid = 1'b1; in_word = 16'h1111; key_word = 16'hA5A5;
      #1;
      checks++; if (in_ready !== 1'b1) $display("FAIL rst_load_hs: got %b want 1", in_ready); else passed++;
      @(negedge clk); in_valid = 1'b0; key_valid = 1'b0;
      checks++; if (crypt_key !== 16'hA5A5) $display("FAIL rst_xor_key: got %h want a5a5", crypt_key); else passed++;
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || crypt_key !== '0 || crypt_msg !== '0 || out_valid !== 1'b0 || out_word !== '0)
         $display("FAIL rst_mid: busy %b ck %h cm %h ov %b ow %h want all zero", busy, crypt_key, crypt_msg, out_valid, out_word);
      else passed++;
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || out_valid !== 1'b0) $display("FAIL rst_quiet: done %b ov %b want 0 0", done, out_valid);
         else passed++;
      end
      m_w[0] = 16'hBEEF; k_w[0] = 16'h1234;
      run_msg(1, 100, 100);
   endtask

   initial begin
      test_reset;
      test_single;
      test_multi;
      test_backpressure;
      test_key_wait;
      test_random;
      test_err_len;
      test_abort;
      test_reset_mid;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
